alu_cmd_driver: RTL and testbench

Command-side driver for the switch/button ALU front end. It accepts one (A, B, opcode) command over a valid/ready handshake and replays it as the switch and button sequence a user would produce: A on btn[0], B on btn[1], opcode on btn[2]. It then waits for the ALU to settle, captures the LED result and returns it on a valid/ready response port. It sits between a command source (bench, UART front end) and the ALU toplevel, and drives the toplevel's switch and button inputs.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_ref_model.sv | 63 ++++++
 rtl/alu_cmd_driver.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, button index and FSM state definitions for the ALU command driver
//
// Purpose: constants shared by alu_cmd_driver, alu_ref_model and the toplevel bench.
// Ports: none (package).
package alu_pkg;

  // ALU opcodes as entered on the switches
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Button index per field; the field counter walks these in order
  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

  // Driver FSM states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETUP   = 3'd1;
  localparam state_t ST_PRESS   = 3'd2;
  localparam state_t ST_RELEASE = 3'd3;
  localparam state_t ST_SETTLE  = 3'd4;
  localparam state_t ST_RESP    = 3'd5;

endpackage

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational reference ALU producing the expected LED value
//
// Purpose: computes the low NB_AB bits of the ALU result for a command, and flags
//          whether the opcode belongs to the known set.
// Ports:
//   i_a, i_b, i_op  in  NB_OP  operands and opcode
//   o_result        out NB_AB  expected LED value
//   o_known         out 1      opcode is one of the package opcodes
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int NB_OP = 6,
  parameter int NB_AB = 4
) (
  input  logic [NB_OP-1:0] i_a,
  input  logic [NB_OP-1:0] i_b,
  input  logic [NB_OP-1:0] i_op,
  output logic [NB_AB-1:0] o_result,
  output logic             o_known
);

  logic [NB_AB-1:0] a_lo;
  logic [NB_AB-1:0] b_lo;
  logic [NB_AB-1:0] srl_lo;
  logic [NB_AB-1:0] sra_lo;

  assign a_lo = i_a[NB_AB-1:0];
  assign b_lo = i_b[NB_AB-1:0];

  // Only the low result bits are built: bit i of a right shift by b is a[i+b],
  // or the fill bit (0 / sign) once i+b runs past the operand.
  always_comb begin
    srl_lo = '0;
    sra_lo = '0;
    for (int i = 0; i < NB_AB; i++) begin
      srl_lo[i] = 1'b0;
      sra_lo[i] = i_a[NB_OP-1];
      for (int j = i; j < NB_OP; j++) begin
        if (i_b == NB_OP'(j - i)) begin
          srl_lo[i] = i_a[j];
          sra_lo[i] = i_a[j];
        end
      end
    end
  end

  always_comb begin
    o_result = '0;
    o_known  = 1'b1;
    case (i_op)
      OP_ADD:  o_result = a_lo + b_lo;
      OP_SUB:  o_result = a_lo - b_lo;
      OP_AND:  o_result = a_lo & b_lo;
      OP_OR:   o_result = a_lo | b_lo;
      OP_XOR:  o_result = a_lo ^ b_lo;
      OP_NOR:  o_result = ~(a_lo | b_lo);
      OP_SRA:  o_result = sra_lo;
      OP_SRL:  o_result = srl_lo;
      default: o_known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - replays one (A, B, op) command as switch/button presses and returns the LED result
//
// Purpose: accepts a command, drives A/B/op onto o_sw with a press on btn[0]/[1]/[2]
//          for each, waits for the ALU to settle, captures i_led and returns it.
// Ports:
//   clock, i_reset                         clock and synchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_a/b/op  command handshake and fields
//   o_sw, o_btn                            switch and button drive toward the ALU
//   i_led                                  ALU LED result
//   o_rsp_valid/i_rsp_ready, o_rsp_data    response handshake and captured LEDs
//   o_rsp_err                              result mismatch flag
// Configuration: define ALU_DRV_CHECK_EN to build the reference model and drive
//                o_rsp_err; otherwise o_rsp_err is constant 0.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int NB_OP      = 6,
  parameter int NB_BTN     = 3,
  parameter int NB_AB      = 4,
  parameter int HOLD_CYC   = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [NB_OP-1:0]  i_cmd_a,
  input  logic [NB_OP-1:0]  i_cmd_b,
  input  logic [NB_OP-1:0]  i_cmd_op,
  output logic [NB_OP-1:0]  o_sw,
  output logic [NB_BTN-1:0] o_btn,
  input  logic [NB_AB-1:0]  i_led,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [NB_AB-1:0]  o_rsp_data,
  output logic              o_rsp_err
);

  localparam int MAX_CYC = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t             state_q, state_d;
  logic [1:0]         fld_q, fld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_OP-1:0]   a_q, a_d;
  logic [NB_OP-1:0]   b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [NB_OP-1:0]   sw_q, sw_d;
  logic [NB_BTN-1:0]  btn_q, btn_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [NB_AB-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [1:0]         fld_next;
  logic [NB_OP-1:0]   field_next;
  logic               chk_err;

`ifdef ALU_DRV_CHECK_EN
  logic [NB_AB-1:0] exp_res;
  logic             exp_known;

  alu_ref_model #(
    .NB_OP (NB_OP),
    .NB_AB (NB_AB)
  ) u_ref_model (
    .i_a      (a_q),
    .i_b      (b_q),
    .i_op     (op_q),
    .o_result (exp_res),
    .o_known  (exp_known)
  );

  // Unknown opcodes have no defined result, so they never flag an error
  assign chk_err = exp_known && (i_led != exp_res);
`else
  assign chk_err = 1'b0;
`endif

  // Switch value for the field entered after the current RELEASE
  assign fld_next = fld_q + 2'd1;
  always_comb begin
    field_next = op_q;
    case (fld_next)
      2'(BTN_A): field_next = a_q;
      2'(BTN_B): field_next = b_q;
      default:   field_next = op_q;
    endcase
  end

  // Outputs are computed from the next state so every output is a flop.
  // Switches only change on SETUP entry and buttons only on PRESS/RELEASE
  // entry, so o_sw and o_btn never move on the same edge.
  always_comb begin
    state_d     = state_q;
    fld_d       = fld_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cmd_ready_d = cmd_ready_q;
    sw_d        = sw_q;
    btn_d       = btn_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          a_d         = i_cmd_a;
          b_d         = i_cmd_b;
          op_d        = i_cmd_op;
          fld_d       = 2'(BTN_A);
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          sw_d        = i_cmd_a;
          btn_d       = '0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          btn_d   = NB_BTN'(1) << fld_q;
          state_d = ST_PRESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESS: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          btn_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (fld_q == 2'(BTN_OP)) begin
            sw_d    = op_q;
            state_d = ST_SETTLE;
          end else begin
            fld_d   = fld_next;
            sw_d    = field_next;
            state_d = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = i_led;
          rsp_err_d   = chk_err;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        btn_d       = '0;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      fld_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cmd_ready_q <= 1'b1;
      sw_q        <= '0;
      btn_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fld_q       <= fld_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cmd_ready_q <= cmd_ready_d;
      sw_q        <= sw_d;
      btn_q       <= btn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_sw        = sw_q;
  assign o_btn       = btn_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver with a latching ALU stand-in
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int H   = 4;
  localparam int S   = 8;
  localparam int LAT = 9 * H + S;
`ifdef ALU_DRV_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       i_reset;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [5:0] i_cmd_a, i_cmd_b, i_cmd_op;
  logic [5:0] o_sw;
  logic [2:0] o_btn;
  logic [3:0] i_led;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [3:0] o_rsp_data;
  logic       o_rsp_err;

  int tests = 0;
  int fails = 0;

  logic       led_force_en = 1'b0;
  logic [3:0] led_force    = 4'd0;
  logic [5:0] env_a = '0, env_b = '0, env_op = '0;
  logic [5:0] op_tab [8];

  always #5 clock = ~clock;

  alu_cmd_driver #(
    .NB_OP(6), .NB_BTN(3), .NB_AB(4), .HOLD_CYC(H), .SETTLE_CYC(S)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_a     (i_cmd_a),
    .i_cmd_b     (i_cmd_b),
    .i_cmd_op    (i_cmd_op),
    .o_sw        (o_sw),
    .o_btn       (o_btn),
    .i_led       (i_led),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err)
  );

  // Behavioural ALU result from the opcode rules, using integer arithmetic
  function automatic logic [3:0] alu_fn(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
    int ia, ib, sa, r;
    ia = int'(a);
    ib = int'(b);
    sa = a[5] ? ia - 64 : ia;
    case (op)
      OP_ADD:  r = ia + ib;
      OP_SUB:  r = ia - ib;
      OP_AND:  r = ia & ib;
      OP_OR:   r = ia | ib;
      OP_XOR:  r = ia ^ ib;
      OP_NOR:  r = ~(ia | ib);
      OP_SRA:  r = sa >>> ib;
      OP_SRL:  r = ia >> ib;
      default: r = 0;
    endcase
    return r[3:0];
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
  endfunction

  // ALU stand-in: each button press latches the switches into its register
  always @(posedge clock) begin
    if (o_btn[0]) env_a  <= o_sw;
    if (o_btn[1]) env_b  <= o_sw;
    if (o_btn[2]) env_op <= o_sw;
  end
  assign i_led = led_force_en ? led_force : alu_fn(env_a, env_b, env_op);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, check the full switch/button replay, then the response
  task automatic run_cmd(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op,
                         input int wait_cyc, input bit pre_ready, input bit chain,
                         input logic [5:0] na, input logic [5:0] nb, input logic [5:0] nop);
    logic [5:0] fv [3];
    logic [3:0] exp_data;
    logic       exp_err;
    logic [5:0] esw;
    logic [2:0] ebtn;
    int         phase, f;
    fv[0] = a; fv[1] = b; fv[2] = op;
    exp_data = led_force_en ? led_force : alu_fn(a, b, op);
    exp_err  = CHECK_EN && op_known(op) && (exp_data != alu_fn(a, b, op));

    i_cmd_valid = 1'b1; i_cmd_a = a; i_cmd_b = b; i_cmd_op = op;
    step();
    for (int t = 0; t < LAT; t++) begin
      // command and response inputs are irrelevant while busy
      i_cmd_valid = 1'($urandom); i_cmd_a = 6'($urandom); i_cmd_b = 6'($urandom); i_cmd_op = 6'($urandom);
      i_rsp_ready = (t == LAT - 1) ? pre_ready : 1'($urandom);
      phase = t / H;
      if (phase < 9) begin
        f    = phase / 3;
        esw  = fv[f];
        ebtn = ((phase % 3) == 1) ? 3'(1 << f) : 3'b000;
      end else begin
        esw  = op;
        ebtn = 3'b000;
      end
      check("seq", {o_cmd_ready, o_sw, o_btn, o_rsp_valid}, {1'b0, esw, ebtn, 1'b0});
      step();
    end
    check("rsp", {o_rsp_valid, o_rsp_data, o_rsp_err, o_cmd_ready}, {1'b1, exp_data, exp_err, 1'b0});
    if (chain) begin
      i_cmd_valid = 1'b1; i_cmd_a = na; i_cmd_b = nb; i_cmd_op = nop;
    end else begin
      i_cmd_valid = 1'b0;
    end
    if (!pre_ready) begin
      i_rsp_ready = 1'b0;
      for (int w = 0; w < wait_cyc; w++) begin
        step();
        check("hold", {o_rsp_valid, o_rsp_data, o_rsp_err, o_cmd_ready}, {1'b1, exp_data, exp_err, 1'b0});
      end
      i_rsp_ready = 1'b1;
    end
    step();
    check("done", {o_rsp_valid, o_cmd_ready}, 2'b01);
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] ra, rb, rop;
    logic       saw_valid;
    op_tab[0] = OP_ADD; op_tab[1] = OP_SUB; op_tab[2] = OP_AND; op_tab[3] = OP_OR;
    op_tab[4] = OP_XOR; op_tab[5] = OP_SRA; op_tab[6] = OP_SRL; op_tab[7] = OP_NOR;
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_a = '0; i_cmd_b = '0; i_cmd_op = '0;
    i_rsp_ready = 1'b0;
    repeat (3) step();
    check("reset", {o_cmd_ready, o_sw, o_btn, o_rsp_valid, o_rsp_data, o_rsp_err}, {1'b1, 6'd0, 3'd0, 1'b0, 4'd0, 1'b0});
    i_reset = 1'b0;
    repeat (2) step();
    check("idle", {o_cmd_ready, o_sw, o_btn, o_rsp_valid}, {1'b1, 6'd0, 3'd0, 1'b0});

    // ADD with ready held high, then SUB with a stalled consumer
    run_cmd(6'd1, 6'd1, OP_ADD, 0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
    run_cmd(6'd5, 6'd3, OP_SUB, 10, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);

    // Reset during PRESS of field B discards the command
    i_cmd_valid = 1'b1; i_cmd_a = 6'd9; i_cmd_b = 6'd4; i_cmd_op = OP_XOR;
    step();
    i_cmd_valid = 1'b0;
    repeat (4 * H + 1) step();
    check("press_b", {o_sw, o_btn}, {6'd4, 3'b010});
    i_reset = 1'b1;
    step();
    check("mid_reset", {o_cmd_ready, o_sw, o_btn, o_rsp_valid, o_rsp_data, o_rsp_err}, {1'b1, 6'd0, 3'd0, 1'b0, 4'd0, 1'b0});
    i_reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < LAT + 16; i++) begin
      step();
      saw_valid = saw_valid | o_rsp_valid;
    end
    check("no_rsp_after_reset", {saw_valid, o_cmd_ready}, 2'b01);

    // Back-to-back: second command offered through the first response
    run_cmd(6'd12, 6'd7, OP_OR, 2, 1'b0, 1'b1, 6'd33, 6'd2, OP_SRA);
    run_cmd(6'd33, 6'd2, OP_SRA, 0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0);

    // Forced LED values against the reference model
    led_force_en = 1'b1; led_force = 4'd7;
    run_cmd(6'd1, 6'd1, OP_ADD, 1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    led_force = 4'd2;
    run_cmd(6'd1, 6'd1, OP_ADD, 0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
    led_force = 4'd5;
    run_cmd(6'd3, 6'd4, 6'b010101, 0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
    led_force_en = 1'b0;

    // Randomized commands
    for (int n = 0; n < 8; n++) begin
      ra  = 6'($urandom);
      rb  = 6'($urandom);
      rop = ($urandom_range(0, 9) < 9) ? op_tab[$urandom_range(0, 7)] : 6'($urandom);
      run_cmd(ra, rb, rop, $urandom_range(0, 5), 1'($urandom), 1'b0, 6'd0, 6'd0, 6'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
